// File: rtl/sum_monitor.sv
// sum_monitor: change-detecting sum sampler with show-ahead record FIFO and sticky overflow/alarm flags
// Ports: clk, rst_n (async active-low); en samples in_val; clr clears sticky flags;
//        out_valid/out_data/out_delta/out_ready form the record stream; full, overflow, alarm are status.
module sum_monitor #(
  parameter int SIZE = 8,
  parameter int DEPTH = 4,
  parameter logic [2*SIZE-1:0] THRESH = 16'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [2*SIZE-1:0] in_val,
  input  logic              clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2*SIZE-1:0] out_data,
  output logic [2*SIZE-1:0] out_delta,
  output logic              full,
  output logic              overflow,
  output logic              alarm
);
  localparam int W = 2 * SIZE;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [W-1:0] prev;
  logic prev_valid;
  logic [W-1:0] data_mem [DEPTH];
  logic [W-1:0] delta_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic change, pop, push, drop;
  assign out_valid = |count;
  assign full = count == FULL_CNT;
  // memory is not reset, so the head is masked while empty to keep outputs zero in reset
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;
  assign out_delta = out_valid ? delta_mem[rd_ptr] : '0;
  always_comb begin
    change = en && prev_valid && in_val != prev;
    pop = out_valid && out_ready;
    push = change && (!full || pop);
    drop = change && full && !pop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      prev_valid <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      alarm <= 1'b0;
    end else begin
      if (en) prev <= in_val;
      if (en) prev_valid <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      overflow <= drop || (overflow && !clr);
      alarm <= (en && in_val > THRESH) || (alarm && !clr);
    end
  end
  // at full with a pop, wr_ptr == rd_ptr: the old head is consumed this edge and the slot is reused
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_val;
      delta_mem[wr_ptr] <= in_val - prev;
    end
  end
endmodule

// File: tb/tb_sum_monitor.sv
// tb_sum_monitor: directed and randomized checks of sum_monitor against a queue-based reference model
module tb_sum_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [15:0] in_val = '0;
  logic clr = 1'b0;
  logic out_ready = 1'b0;
  logic out_valid, full, overflow, alarm;
  logic [15:0] out_data, out_delta;
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic [15:0] d; logic [15:0] dl;} rec_t;
  rec_t q[$];
  logic [15:0] m_prev;
  bit m_pv, m_ovf, m_alm;

  sum_monitor #(.SIZE(8), .DEPTH(4), .THRESH(16'h0100)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_val(in_val), .clr(clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_delta(out_delta),
    .full(full), .overflow(overflow), .alarm(alarm)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_prev = '0;
    m_pv = 0;
    m_ovf = 0;
    m_alm = 0;
  endtask

  // drive one edge and advance the reference model by the same edge
  task automatic drive(input logic e, input logic [15:0] v, input logic c, input logic r);
    bit was_full, popm, chg;
    en = e; in_val = v; clr = c; out_ready = r;
    @(posedge clk);
    was_full = q.size() == 4;
    popm = r && q.size() != 0;
    chg = e && m_pv && v != m_prev;
    if (popm) void'(q.pop_front());
    if (chg && (!was_full || popm)) q.push_back({v, 16'(v - m_prev)});
    m_ovf = (chg && was_full && !popm) || (m_ovf && !c);
    m_alm = (e && v > 16'h0100) || (m_alm && !c);
    if (e) begin m_prev = v; m_pv = 1; end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (out_data !== 16'h0 || out_delta !== 16'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", out_data, out_delta); end
    checks++; if (overflow !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", overflow, alarm); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_prime_change();
    drive(1, 16'd5, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL prime_no_record got=%b exp=0", out_valid); end
    drive(1, 16'd9, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL change_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 16'd9 || out_delta !== 16'd4) begin failures++; $display("FAIL change_rec got=%h/%h exp=0009/0004", out_data, out_delta); end
  endtask

  task automatic test_no_change();
    for (int i = 0; i < 10; i++) drive(1, 16'd9, 0, 0);
    checks++; if (out_data !== 16'd9 || full !== 1'b0) begin failures++; $display("FAIL hold_head got=%h full=%b exp=0009 full=0", out_data, full); end
    drive(0, 16'd9, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_count got valid=%b exp=0 after one pop", out_valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) drive(1, 16'(20 + i), 0, 0);
    checks++; if (full !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_flags got full=%b ovf=%b exp=1/1", full, overflow); end
    checks++; if (out_data !== 16'd20 || out_delta !== 16'd11) begin failures++; $display("FAIL ovf_head got=%h/%h exp=0014/000b", out_data, out_delta); end
    drive(0, 16'd0, 1, 0);
    checks++; if (overflow !== 1'b0 || full !== 1'b1 || out_data !== 16'd20) begin failures++; $display("FAIL ovf_clr got ovf=%b full=%b head=%h exp=0/1/0014", overflow, full, out_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== 16'(20 + i)) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", out_data, 16'(20 + i)); end
      drive(0, 16'd0, 0, 1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap_alarm();
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_idle got=%b exp=0", alarm); end
    drive(1, 16'hFFFF, 0, 0);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_set got=%b exp=1", alarm); end
    drive(1, 16'h0000, 0, 0);
    drive(0, 16'h0000, 0, 1);
    checks++; if (out_data !== 16'h0000 || out_delta !== 16'h0001 || out_valid !== 1'b1) begin failures++; $display("FAIL wrap_delta got=%h/%h v=%b exp=0000/0001 v=1", out_data, out_delta, out_valid); end
    drive(0, 16'h0000, 1, 0);
    checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL alarm_clr got=%b exp=0", alarm); end
    drive(1, 16'h0200, 1, 0);
    checks++; if (alarm !== 1'b1) begin failures++; $display("FAIL alarm_set_wins got=%b exp=1", alarm); end
    drive(0, 16'h0000, 1, 1);
    drive(0, 16'h0000, 0, 1);
    checks++; if (out_valid !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL wrap_drain got v=%b alarm=%b exp=0/0", out_valid, alarm); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) drive(1, 16'(16'h0300 + i), 0, 0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b exp=1", full); end
    drive(1, 16'h0305, 0, 1);
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_count got full=%b ovf=%b exp=1/0", full, overflow); end
    checks++; if (out_data !== 16'h0302 || out_delta !== 16'h0001) begin failures++; $display("FAIL b2b_head got=%h/%h exp=0302/0001", out_data, out_delta); end
    for (int i = 0; i < 4; i++) drive(0, 16'h0, 1, 1);
    checks++; if (out_valid !== 1'b0 || alarm !== 1'b0) begin failures++; $display("FAIL b2b_drain got v=%b alarm=%b exp=0/0", out_valid, alarm); end
  endtask

  task automatic test_midstream_reset();
    drive(1, 16'h0010, 0, 0);
    drive(1, 16'h0011, 0, 0);
    drive(1, 16'h0012, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin failures++; $display("FAIL async_reset got v=%b d=%h exp=0/0000", out_valid, out_data); end
    #2 rst_n = 1'b1;
    drive(1, 16'h0042, 0, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_reprime got=%b exp=0", out_valid); end
    drive(1, 16'h0043, 0, 0);
    checks++; if (out_data !== 16'h0043 || out_delta !== 16'h0001) begin failures++; $display("FAIL reset_first_rec got=%h/%h exp=0043/0001", out_data, out_delta); end
  endtask

  task automatic test_random();
    bit ev;
    logic [15:0] ed, edl;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'(16'h00FC + $urandom_range(0, 7)),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      ev = q.size() != 0;
      ed = ev ? q[0].d : 16'h0;
      edl = ev ? q[0].dl : 16'h0;
      checks++; if (out_valid !== ev || full !== (q.size() == 4)) begin failures++; $display("FAIL rnd_status cyc=%0d got v=%b f=%b exp v=%b f=%b", i, out_valid, full, ev, q.size() == 4); end
      checks++; if (out_data !== ed || out_delta !== edl) begin failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, out_data, out_delta, ed, edl); end
      checks++; if (overflow !== m_ovf || alarm !== m_alm) begin failures++; $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", i, overflow, alarm, m_ovf, m_alm); end
    end
  endtask

  initial begin
    test_reset();
    test_prime_change();
    test_no_change();
    test_overflow();
    test_wrap_alarm();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sum_monitor.md
SUM_MONITOR -- requirements
Module: sum_monitor

Interface
REQ-001 Parameter SIZE SHALL be: SIZE, default 8, half-width of the monitored sum bus (bus width W = 2*SIZE).
REQ-002 Parameter DEPTH SHALL be: DEPTH, default 4, number of change-record entries, power of two, minimum 2.
REQ-003 Parameter THRESH SHALL be: THRESH, default 16'h0100, alarm threshold, compared as W-bit unsigned.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
REQ-005 Port: clk  input  1  sole clock, rising edge.
REQ-006 Port: rst_n  input  1  asynchronous active-low reset.
REQ-007 Port: en  input  1  sample enable.
REQ-008 Port: in_val  input  W  sum bus from the upstream four-counter adder.
REQ-009 Port: clr  input  1  synchronous clear of sticky flags.
REQ-010 Port: out_ready  input  1  consumer ready.
REQ-011 Port: out_valid  output  1  record available at FIFO head.
REQ-012 Port: out_data  output  W  sampled value of the head record.
REQ-013 Port: out_delta  output  W  in_val minus previous sample, modulo 2^W.
REQ-014 Port: full  output  1  FIFO holds DEPTH records.
REQ-015 Port: overflow  output  1  sticky flag: a record was dropped.
REQ-016 Port: alarm  output  1  sticky flag: a sample exceeded THRESH.

Function
REQ-017 Internal state SHALL be: prev (W bits), prev_valid, FIFO storage, read/write pointers, and a count of 0..DEPTH.
REQ-018 Sampling SHALL occur only on rising clk edges with en=1.
REQ-019 With en=1 and prev_valid=0, the block SHALL load prev with in_val, set prev_valid, and push no record.
REQ-020 With en=1, prev_valid=1 and in_val!=prev, the block SHALL push {in_val, (in_val-prev) mod 2^W} and load prev with in_val.
REQ-021 With en=1 and in_val==prev, the block SHALL push nothing and leave all state unchanged.
REQ-022 Delta SHALL wrap: 16'h0000 after 16'hFFFF gives delta 16'h0001.
REQ-023 The FIFO SHALL be show-ahead: out_data and out_delta reflect the head record whenever out_valid=1; out_valid = (count!=0).
REQ-024 A pop SHALL occur on an edge where out_valid=1 and out_ready=1.
REQ-025 Latency: a record pushed at edge k SHALL appear with out_valid=1 immediately after edge k when the FIFO was empty.
REQ-026 Push when full without a pop: the record SHALL be dropped, overflow set, and prev still updated.
REQ-027 Push and pop on the same edge SHALL both succeed at any count, including full; count is unchanged.
REQ-028 Pop when empty SHALL be impossible because out_valid=0; out_ready is ignored.
REQ-029 full SHALL equal (count==DEPTH) and be combinational from the registered count.
REQ-030 alarm SHALL be set on any edge with en=1 and in_val > THRESH, independent of the change test.
REQ-031 clr=1 SHALL clear overflow and alarm; if a set condition occurs on the same edge, set wins.
REQ-032 clr SHALL NOT affect the FIFO, prev or prev_valid.
REQ-033 Pointers SHALL wrap modulo DEPTH.
REQ-034 All outputs SHALL be glitch-free registered values or functions of registers only; there is no combinational path from in_val to any output.

Reset
REQ-035 On rst_n=0 (asynchronous), the block SHALL set count, pointers, prev, prev_valid, overflow and alarm to 0.
REQ-036 During reset, out_valid=0, full=0, out_data=0 and out_delta=0.
REQ-037 Reset asserted mid-stream SHALL discard all queued records; the first enabled sample after release only primes prev (per REQ-019).
REQ-038 Release of rst_n SHALL take effect at the first rising clk edge after deassertion.

Verification (SIZE=8, DEPTH=4, THRESH=16'h0100)
REQ-039 Prime and change: en=1, in_val=5 then 9, out_ready=0 -> after the second edge, out_valid=1, out_data=9, out_delta=4.
REQ-040 No change: in_val held at 9 for 10 edges -> count remains 1, no new records.
REQ-041 Overflow: 6 distinct values with out_ready=0 -> full=1, count=4, overflow=1, head is the first change record; then clr=1 -> overflow=0 and FIFO intact.
REQ-042 Wrap and alarm: in_val=16'hFFFF then 16'h0000 -> record delta=16'h0001; alarm=1 after the 16'hFFFF sample.
REQ-043 Full with simultaneous push and pop: FIFO full, out_ready=1, new value in -> count stays 4, overflow stays 0, head advances by one record.
REQ-044 Mid-stream reset: assert rst_n=0 asynchronously with 3 records queued -> out_valid=0 immediately; after release, the first sample produces no record.
